// File: rtl/pixel_fill_engine_if.sv
// Avalon-MM write-only bus between the fill engine and the SDRAM
// arbiter. The engine drives the master side. Anything that accepts
// pixel writes uses the slave side.
interface pixel_fill_engine_if;
   logic [31:0] m_address;
   logic [31:0] m_writedata;
   logic        m_write;
   logic        m_waitrequest;

   modport master (
      output m_address,
      output m_writedata,
      output m_write,
      input  m_waitrequest
   );

   modport slave (
      input  m_address,
      input  m_writedata,
      input  m_write,
      output m_waitrequest
   );
endinterface

// File: rtl/pixel_fill_engine.sv
// Clear-before-render engine. It floods an entire pixel buffer with a
// single RGB565 colour. Two pixels are packed into each 32-bit word, and
// the words are walked row by row through the Avalon-MM master port.
// A one-cycle done pulse marks the end of a fill or of an aborted fill.
module pixel_fill_engine #(
   parameter logic [15:0] H_RESOLUTION = 16'd256,
   parameter logic [15:0] V_RESOLUTION = 16'd192,
   parameter logic [31:0] ROW_STRIDE   = 32'd1024
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       abort,
   input  logic [31:0]                base_addr,
   input  logic [15:0]                colour,
   output logic                       busy,
   output logic                       done,
   pixel_fill_engine_if.master        m
);

   localparam int WORDS_PER_ROW = int'(H_RESOLUTION) / 2;
   localparam int COL_W         = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(WORDS_PER_ROW - 1);
   localparam logic [15:0]      ROW_LAST = V_RESOLUTION - 16'd1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t            state;
   logic [COL_W-1:0]  col;
   logic [15:0]       row;
   logic [31:0]       row_addr;
   logic              abort_q;
   logic              last_word;

   // The word currently on the bus is the final one of the frame when it
   // sits in the last column of the last row.
   assign last_word = (col == COL_LAST) && (row == ROW_LAST);

   // Main sequencer. The bus outputs are registered. m_address is advanced
   // incrementally: +4 within a row, or jumped to the next row start. This
   // keeps it equal to row_addr + 4*col without needing a multiplier.
   // Nothing moves while the slave stalls. An abort seen during a stall is
   // remembered so that the stalled word still completes before stopping.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         busy          <= 1'b0;
         done          <= 1'b0;
         m.m_write     <= 1'b0;
         m.m_address   <= '0;
         m.m_writedata <= '0;
         col           <= '0;
         row           <= '0;
         row_addr      <= '0;
         abort_q       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state         <= WRITE;
                  busy          <= 1'b1;
                  m.m_write     <= 1'b1;
                  m.m_address   <= base_addr;
                  m.m_writedata <= {colour, colour};
                  row_addr      <= base_addr;
                  col           <= '0;
                  row           <= '0;
                  abort_q       <= 1'b0;
               end
            end

            WRITE: begin
               if (m.m_waitrequest) begin
                  if (abort) begin
                     abort_q <= 1'b1;
                  end
               end else if (last_word || abort || abort_q) begin
                  state     <= DONE;
                  m.m_write <= 1'b0;
                  done      <= 1'b1;
                  abort_q   <= 1'b0;
                  col       <= '0;
                  row       <= '0;
               end else if (col == COL_LAST) begin
                  col         <= '0;
                  row         <= row + 16'd1;
                  row_addr    <= row_addr + ROW_STRIDE;
                  m.m_address <= row_addr + ROW_STRIDE;
               end else begin
                  col         <= col + 1'b1;
                  m.m_address <= m.m_address + 32'd4;
               end
            end

            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               state     <= IDLE;
               busy      <= 1'b0;
               done      <= 1'b0;
               m.m_write <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pixel_fill_engine.sv
// Directed bench for pixel_fill_engine on its default 256x192 geometry.
// Each fill is watched cycle by cycle on the falling edge. Every accepted
// word is checked against base + row*1024 + col*4.
module tb_pixel_fill_engine;

   localparam int TOTAL_WORDS = 24576;
   localparam int BUDGET      = 40000;

   localparam int MODE_CLEAN = 0;
   localparam int MODE_STALL = 1;
   localparam int MODE_ABORT = 2;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic        abort;
   logic [31:0] base_addr;
   logic [15:0] colour;
   logic        busy;
   logic        done;

   pixel_fill_engine_if bus ();

   pixel_fill_engine dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .abort     (abort),
      .base_addr (base_addr),
      .colour    (colour),
      .busy      (busy),
      .done      (done),
      .m         (bus)
   );

   // 100 MHz free-running clock
   always #5 clock = ~clock;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   // Results gathered by runFill for later checking
   int          accepts;
   int          write_cycles;
   int          gap_cycles;
   int          addr_err;
   int          data_err;
   int          stab_err;
   int          done_count;
   int          writes_after_done;
   bit          done_right_after_last;
   bit          busy_after_done;
   bit          done_after_done;
   bit          first_write_high;
   bit          timed_out;
   logic [31:0] addr_log [0:2];
   logic [31:0] addr_128;
   logic [31:0] last_addr;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) passes++;
      else begin
         fails++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] new_base, input logic [15:0] new_colour);
      @(negedge clock);
      start     = 1'b1;
      base_addr = new_base;
      colour    = new_colour;
      @(negedge clock);
      start     = 1'b0;
   endtask

   // Start a fill and follow it to completion. The address model always uses model_base.
   task automatic runFill(input logic [31:0] model_base, input logic [15:0] fill_colour, input int mode);
      int          stall_left;
      bit          prev_stall;
      bit          prev_accept;
      bit          done_seen;
      logic [31:0] prev_addr;
      logic [31:0] prev_data;
      logic [31:0] exp_addr;
      accepts = 0; write_cycles = 0; gap_cycles = 0; addr_err = 0; data_err = 0;
      stab_err = 0; done_count = 0; writes_after_done = 0; done_right_after_last = 0;
      busy_after_done = 1; done_after_done = 1; timed_out = 1;
      stall_left = 0; prev_stall = 0; prev_accept = 0; done_seen = 0;
      prev_addr = '0; prev_data = '0;
      bus.m_waitrequest = 1'b0;
      applyStimulus(model_base, fill_colour);
      first_write_high = bus.m_write;
      for (int cyc = 0; cyc < BUDGET; cyc++) begin
         if (cyc > 0) @(negedge clock);
         start = 1'b0;
         abort = 1'b0;
         if (done_seen) begin
            busy_after_done = busy;
            done_after_done = done;
            if (bus.m_write) writes_after_done++;
            timed_out = 0;
            break;
         end
         if (done) begin
            done_count++;
            done_seen = 1;
            if (prev_accept) done_right_after_last = 1;
            if (bus.m_write) writes_after_done++;
            bus.m_waitrequest = 1'b0;
            prev_accept = 0;
            continue;
         end
         if (bus.m_write) begin
            write_cycles++;
            if (prev_stall && (bus.m_address !== prev_addr || bus.m_writedata !== prev_data)) stab_err++;
            if (!prev_stall) begin
               stall_left = 0;
               if (mode == MODE_STALL) begin
                  if (accepts == 0) stall_left = 3;
                  else if ($urandom_range(0, 7) == 0) stall_left = int'($urandom_range(1, 2));
                  if (accepts == 100) begin
                     start     = 1'b1;
                     base_addr = 32'h0900_0000;
                  end
               end
               if (mode == MODE_ABORT && accepts == 50) begin
                  stall_left = 2;
                  abort      = 1'b1;
               end
            end
            bus.m_waitrequest = (stall_left > 0);
            if (stall_left > 0) stall_left--;
            prev_stall = bus.m_waitrequest;
            prev_addr  = bus.m_address;
            prev_data  = bus.m_writedata;
            if (!bus.m_waitrequest) begin
               exp_addr = model_base + 32'(accepts / 128) * 32'd1024 + 32'(accepts % 128) * 32'd4;
               if (bus.m_address !== exp_addr) addr_err++;
               if (bus.m_writedata !== {fill_colour, fill_colour}) data_err++;
               if (accepts < 3) addr_log[accepts] = bus.m_address;
               if (accepts == 128) addr_128 = bus.m_address;
               last_addr = bus.m_address;
               accepts++;
               prev_accept = 1;
            end else begin
               prev_accept = 0;
            end
         end else begin
            gap_cycles++;
            bus.m_waitrequest = 1'b0;
            prev_stall  = 0;
            prev_accept = 0;
         end
      end
      start = 1'b0;
      abort = 1'b0;
      bus.m_waitrequest = 1'b0;
   endtask

   // Directed sequence: reset, clean fill, stalled fill with ignored start,
   // aborted fill, then asynchronous reset mid-fill followed by a restart.
   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0;
      base_addr = '0; colour = '0; bus.m_waitrequest = 1'b0;
      addr_128 = '0; last_addr = '0;
      for (int i = 0; i < 3; i++) addr_log[i] = '0;
      repeat (3) @(negedge clock);
      checkOutput("reset_m_write", 32'(bus.m_write), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_address", bus.m_address, 32'h0);
      checkOutput("reset_writedata", bus.m_writedata, 32'h0);
      reset = 1'b0;
      @(negedge clock);

      $display("[TB] clean fill at 0x08000000");
      runFill(32'h0800_0000, 16'hF800, MODE_CLEAN);
      checkOutput("clean_timeout", 32'(timed_out), 32'd0);
      checkOutput("clean_first_latency", 32'(first_write_high), 32'd1);
      checkOutput("clean_addr0", addr_log[0], 32'h0800_0000);
      checkOutput("clean_addr1", addr_log[1], 32'h0800_0004);
      checkOutput("clean_addr2", addr_log[2], 32'h0800_0008);
      checkOutput("clean_data_errors", 32'(data_err), 32'd0);
      checkOutput("clean_addr129", addr_128, 32'h0800_0400);
      checkOutput("clean_last_addr", last_addr, 32'h0802_FDFC);
      checkOutput("clean_word_count", 32'(accepts), 32'(TOTAL_WORDS));
      checkOutput("clean_write_cycles", 32'(write_cycles), 32'(TOTAL_WORDS));
      checkOutput("clean_gap_cycles", 32'(gap_cycles), 32'd0);
      checkOutput("clean_addr_errors", 32'(addr_err), 32'd0);
      checkOutput("clean_done_count", 32'(done_count), 32'd1);
      checkOutput("clean_done_after_last", 32'(done_right_after_last), 32'd1);
      checkOutput("clean_done_single", 32'(done_after_done), 32'd0);
      checkOutput("clean_busy_falls", 32'(busy_after_done), 32'd0);

      $display("[TB] stalled fill with stray start at word 100");
      runFill(32'h0800_0000, 16'h001F, MODE_STALL);
      checkOutput("stall_timeout", 32'(timed_out), 32'd0);
      checkOutput("stall_stability", 32'(stab_err), 32'd0);
      checkOutput("stall_first_addr", addr_log[0], 32'h0800_0000);
      checkOutput("stall_word_count", 32'(accepts), 32'(TOTAL_WORDS));
      checkOutput("stall_had_stalls", 32'(write_cycles > TOTAL_WORDS + 3), 32'd1);
      checkOutput("stall_addr_errors", 32'(addr_err), 32'd0);
      checkOutput("stall_data_errors", 32'(data_err), 32'd0);
      checkOutput("stall_last_addr", last_addr, 32'h0802_FDFC);
      checkOutput("stall_done_count", 32'(done_count), 32'd1);
      checkOutput("stall_busy_falls", 32'(busy_after_done), 32'd0);

      $display("[TB] abort at word 50 during a 2-cycle stall");
      runFill(32'h0800_0000, 16'h07E0, MODE_ABORT);
      checkOutput("abort_timeout", 32'(timed_out), 32'd0);
      checkOutput("abort_word_count", 32'(accepts), 32'd51);
      checkOutput("abort_last_addr", last_addr, 32'h0800_00C8);
      checkOutput("abort_stability", 32'(stab_err), 32'd0);
      checkOutput("abort_writes_after", 32'(writes_after_done), 32'd0);
      checkOutput("abort_done_count", 32'(done_count), 32'd1);
      checkOutput("abort_done_after_last", 32'(done_right_after_last), 32'd1);
      checkOutput("abort_busy_falls", 32'(busy_after_done), 32'd0);

      $display("[TB] asynchronous reset mid-fill");
      applyStimulus(32'h0A00_0000, 16'hFFFF);
      repeat (20) @(negedge clock);
      checkOutput("pre_reset_busy", 32'(busy), 32'd1);
      #2 reset = 1'b1;
      #1;
      checkOutput("async_m_write", 32'(bus.m_write), 32'd0);
      checkOutput("async_busy", 32'(busy), 32'd0);
      checkOutput("async_done", 32'(done), 32'd0);
      checkOutput("async_address", bus.m_address, 32'h0);
      @(negedge clock);
      checkOutput("held_reset_done", 32'(done), 32'd0);
      reset = 1'b0;
      @(negedge clock);
      checkOutput("post_reset_done", 32'(done), 32'd0);
      applyStimulus(32'h0B00_0000, 16'h1234);
      checkOutput("restart_m_write", 32'(bus.m_write), 32'd1);
      checkOutput("restart_addr0", bus.m_address, 32'h0B00_0000);
      checkOutput("restart_data", bus.m_writedata, 32'h1234_1234);
      @(negedge clock);
      checkOutput("restart_addr1", bus.m_address, 32'h0B00_0004);

      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
